// File: rtl/toy_mvm_engine.sv
// Matrix-vector multiply engine: y = W * x over a one-cycle-latency memory.
// Result path: arithmetic shift, optional saturation, optional ReLU.
module toy_mvm_engine #(
    parameter int WORD_SIZE = 16,
    parameter int ACC_SIZE  = 40,
    parameter int ADDR_SIZE = 10,
    parameter int MAX_COLS  = 16,
    parameter int DIM_SIZE  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] mat_addr,
    input  logic [ADDR_SIZE-1:0] vec_addr,
    input  logic [ADDR_SIZE-1:0] out_addr,
    input  logic [DIM_SIZE-1:0]  rows,
    input  logic [DIM_SIZE-1:0]  cols,
    input  logic [4:0]           shift,
    input  logic                 sat_en,
    input  logic                 relu_en,
    output logic                 rd_en,
    output logic [ADDR_SIZE-1:0] rd_addr,
    input  logic [WORD_SIZE-1:0] rd_data,
    output logic                 wr_en,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic [WORD_SIZE-1:0] wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int IW = $clog2(MAX_COLS);
    localparam logic signed [ACC_SIZE-1:0] SMAX =
        {{(ACC_SIZE-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
    localparam logic signed [ACC_SIZE-1:0] SMIN = ~SMAX;

    typedef enum logic [2:0] {IDLE, LOAD_VEC, MAC, WRITE, DONE} state_t;

    state_t                     state, state_nx;
    logic [ADDR_SIZE-1:0]       mat_ptr, vec_q, out_q;
    logic [DIM_SIZE-1:0]        rows_q, cols_q, cnt, row;
    logic [4:0]                 shift_q;
    logic                       sat_q, relu_q, err_q;
    logic signed [ACC_SIZE-1:0] acc;
    logic signed [WORD_SIZE-1:0] vbuf [MAX_COLS];

    logic                         cfg_bad, last_cnt, last_row;
    logic [IW-1:0]                bidx;
    logic signed [2*WORD_SIZE-1:0] prod;
    logic signed [ACC_SIZE-1:0]   prod_ext, acc_sh;
    logic [WORD_SIZE-1:0]         res;

    assign cfg_bad  = (rows == '0) || (cols == '0) ||
                      (cols > DIM_SIZE'(MAX_COLS));
    assign last_cnt = (cnt == cols_q);
    assign last_row = (row == rows_q - DIM_SIZE'(1));
    // Capture for beat c happens one cycle after its read, so lag by one.
    assign bidx     = IW'(cnt - DIM_SIZE'(1));
    assign prod     = $signed(rd_data) * vbuf[bidx];
    assign prod_ext = ACC_SIZE'(prod);
    assign acc_sh   = acc >>> shift_q;

    always_comb begin
        res = acc_sh[WORD_SIZE-1:0];
        if (sat_q) begin
            if (acc_sh > SMAX)
                res = SMAX[WORD_SIZE-1:0];
            else if (acc_sh < SMIN)
                res = SMIN[WORD_SIZE-1:0];
        end
        if (relu_q && res[WORD_SIZE-1])
            res = '0;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (start) state_nx = cfg_bad ? DONE : LOAD_VEC;
            LOAD_VEC: if (last_cnt) state_nx = MAC;
            MAC:      if (last_cnt) state_nx = WRITE;
            WRITE:    state_nx = last_row ? DONE : MAC;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_ptr <= '0;
            vec_q   <= '0;
            out_q   <= '0;
            rows_q  <= '0;
            cols_q  <= '0;
            shift_q <= '0;
            sat_q   <= 1'b0;
            relu_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt     <= '0;
            row     <= '0;
            acc     <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    mat_ptr <= mat_addr;
                    vec_q   <= vec_addr;
                    out_q   <= out_addr;
                    rows_q  <= rows;
                    cols_q  <= cols;
                    shift_q <= shift;
                    sat_q   <= sat_en;
                    relu_q  <= relu_en;
                    err_q   <= cfg_bad;
                    cnt     <= '0;
                    row     <= '0;
                    acc     <= '0;
                end
                LOAD_VEC: begin
                    cnt <= last_cnt ? '0 : cnt + DIM_SIZE'(1);
                    if (last_cnt) acc <= '0;
                end
                MAC: begin
                    if (cnt != '0) acc <= acc + prod_ext;
                    if (!last_cnt) mat_ptr <= mat_ptr + ADDR_SIZE'(1);
                    cnt <= last_cnt ? '0 : cnt + DIM_SIZE'(1);
                end
                WRITE: begin
                    acc <= '0;
                    if (!last_row) row <= row + DIM_SIZE'(1);
                end
                DONE: row <= '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD_VEC && cnt != '0)
            vbuf[bidx] <= $signed(rd_data);
    end

    assign rd_en   = (state == LOAD_VEC || state == MAC) && (cnt < cols_q);
    assign rd_addr = (state == MAC) ? mat_ptr : vec_q + ADDR_SIZE'(cnt);
    assign wr_en   = (state == WRITE);
    assign wr_addr = out_q + ADDR_SIZE'(row);
    assign wr_data = res;
    assign busy    = (state == LOAD_VEC) || (state == MAC) || (state == WRITE);
    assign done    = (state == DONE);
    assign err     = err_q;

endmodule

// File: doc/toy_mvm_engine.md
TOY_MVM_ENGINE -- requirements
Module: toy_mvm_engine

Interface
REQ-001 Parameters SHALL be: WORD_SIZE, 16, operand/result width; ACC_SIZE, 40, accumulator width (>= 2*WORD_SIZE); ADDR_SIZE, 10, memory address width; MAX_COLS, 16, vector buffer depth; DIM_SIZE, 5, width of rows/cols fields (must hold MAX_COLS).
REQ-002 Ports SHALL be: clk in 1 clock; rst_n in 1 async active-low reset; start in 1 job request pulse; mat_addr in ADDR_SIZE matrix base; vec_addr in ADDR_SIZE vector base; out_addr in ADDR_SIZE result base; rows in DIM_SIZE row count; cols in DIM_SIZE column count; shift in 5 arithmetic right shift; sat_en in 1 saturate mode; relu_en in 1 ReLU mode; rd_en out 1 read strobe; rd_addr out ADDR_SIZE read address; rd_data in WORD_SIZE read data; wr_en out 1 write strobe; wr_addr out ADDR_SIZE write address; wr_data out WORD_SIZE write data; busy out 1 job active; done out 1 completion pulse; err out 1 sticky config error.
REQ-003 The design SHALL use one clock, clk; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-004 Job: y[r] = sum over c of W[mat_addr + r*cols + c] * x[vec_addr + c], r = 0..rows-1, c = 0..cols-1, written to out_addr + r; all operands signed two's complement.
REQ-005 start SHALL be accepted only in IDLE; rising-edge sample of start in IDLE latches all config inputs; start outside IDLE is ignored.
REQ-006 States SHALL be IDLE, LOAD_VEC, MAC, WRITE, DONE.
REQ-007 Acceptance with rows==0, cols==0 or cols>MAX_COLS: go to DONE next cycle, set err, issue no rd_en/wr_en.
REQ-008 Valid acceptance: err cleared, go to LOAD_VEC, busy=1 from the next cycle until DONE exits.
REQ-009 Memory read latency is one cycle: rd_data valid the cycle after rd_en.
REQ-010 LOAD_VEC: rd_en on cols consecutive cycles at vec_addr..vec_addr+cols-1; each returned word stored into vector buffer index c; exit to MAC after last capture (cols+1 cycles).
REQ-011 MAC per row: acc cleared on entry; rd_en on cols consecutive cycles at matrix addresses; each returned word multiplied by buffer[c] and added; exit to WRITE after last accumulation (cols+1 cycles).
REQ-012 Product SHALL be full 2*WORD_SIZE signed, sign-extended to ACC_SIZE; accumulator wraps modulo 2^ACC_SIZE.
REQ-013 Result pipeline in WRITE: acc >>> shift (arithmetic); then if sat_en clamp to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1] else truncate to low WORD_SIZE bits; then if relu_en negative -> 0.
REQ-014 WRITE: wr_en=1 for exactly one cycle with wr_addr=out_addr+r, wr_data per REQ-013; then MAC for next row or DONE after row rows-1.
REQ-015 All address arithmetic SHALL wrap modulo 2^ADDR_SIZE.
REQ-016 DONE: done=1 for exactly one cycle, busy=0, return to IDLE; a new start may be accepted the following cycle.
REQ-017 rd_en and wr_en SHALL never be high in the same cycle; rd_addr/wr_addr/wr_data are don't-care when their strobe is low.
REQ-018 Busy duration for valid job SHALL be (cols+1) + rows*(cols+2) cycles, DONE excluded.

Reset
REQ-019 rst_n low SHALL immediately force IDLE, busy=0, done=0, err=0, rd_en=0, wr_en=0, accumulator and counters 0; vector buffer contents unspecified.
REQ-020 Reset mid-job SHALL abort with no further memory access; after release the block waits in IDLE for start.

Verification
REQ-021 rows=2, cols=3, x=[1,2,3], W=[1,1,1; -2,0,4], shift=0, modes off -> writes 6 at out_addr, 10 at out_addr+1; done once; busy 14 cycles.
REQ-022 rows=1, cols=1, x=[200], W=[200], sat_en=1, shift=0 -> wr_data 32767; sat_en=0 -> 0x9C40; shift=2, sat_en=0 -> 10000.
REQ-023 rows=1, cols=2, x=[3,-5], W=[1,1], relu_en=1 -> wr_data 0; relu_en=0 -> 0xFFFE.
REQ-024 cols=0, then cols=17 -> err=1, done one cycle after start, no rd_en/wr_en; next valid job clears err.
REQ-025 mat_addr=1022, cols=4 -> reads at 1022,1023,0,1; start pulsed while busy -> ignored, results unchanged.
REQ-026 rst_n pulsed low during MAC of row 1 -> all outputs 0 asynchronously, no wr_en for row 1; subsequent job completes correctly.
